// File: rtl/alu_decode.sv
// Decode/issue stage: turns one LA32R word plus two register reads into the
// one-hot ALU control word and operands, held in a valid/ready register toward EXE.
module alu_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [11:0] out_alu_control,
  output logic [31:0] out_alu_rj,
  output logic [31:0] out_alu_rk,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_ine
);

  typedef enum logic [2:0] {
    K_ILL, K_3R, K_SH3, K_SHI, K_SIMM, K_ZIMM, K_LUI
  } kind_e;

  localparam logic [11:0] C_ADD  = 12'h800;
  localparam logic [11:0] C_SUB  = 12'h400;
  localparam logic [11:0] C_SLT  = 12'h200;
  localparam logic [11:0] C_SLTU = 12'h100;
  localparam logic [11:0] C_AND  = 12'h080;
  localparam logic [11:0] C_NOR  = 12'h040;
  localparam logic [11:0] C_OR   = 12'h020;
  localparam logic [11:0] C_XOR  = 12'h010;
  localparam logic [11:0] C_SLL  = 12'h008;
  localparam logic [11:0] C_SRL  = 12'h004;
  localparam logic [11:0] C_SRA  = 12'h002;
  localparam logic [11:0] C_LUI  = 12'h001;

  kind_e       kind;
  logic [11:0] ctrl_d;
  logic [31:0] rj_d, rk_d;
  logic        we_d, ine_d, capture, valid_d;

  logic        valid_q;
  logic [31:0] pc_q;
  logic [11:0] ctrl_q;
  logic [31:0] rj_q, rk_q;
  logic [4:0]  rd_q;
  logic        we_q, ine_q;

  assign rf_raddr1 = in_inst[9:5];
  assign rf_raddr2 = in_inst[14:10];
  assign in_ready  = ~valid_q | out_ready;
  assign capture   = in_valid & in_ready & ~flush;

  // Immediate forms reuse the control bit of their 3R counterpart.
  always_comb begin
    kind   = K_ILL;
    ctrl_d = '0;
    case (in_inst[31:15])
      17'h00020: begin kind = K_3R;  ctrl_d = C_ADD;  end
      17'h00022: begin kind = K_3R;  ctrl_d = C_SUB;  end
      17'h00024: begin kind = K_3R;  ctrl_d = C_SLT;  end
      17'h00025: begin kind = K_3R;  ctrl_d = C_SLTU; end
      17'h00028: begin kind = K_3R;  ctrl_d = C_NOR;  end
      17'h00029: begin kind = K_3R;  ctrl_d = C_AND;  end
      17'h0002a: begin kind = K_3R;  ctrl_d = C_OR;   end
      17'h0002b: begin kind = K_3R;  ctrl_d = C_XOR;  end
      17'h0002e: begin kind = K_SH3; ctrl_d = C_SLL;  end
      17'h0002f: begin kind = K_SH3; ctrl_d = C_SRL;  end
      17'h00030: begin kind = K_SH3; ctrl_d = C_SRA;  end
      17'h00081: begin kind = K_SHI; ctrl_d = C_SLL;  end
      17'h00089: begin kind = K_SHI; ctrl_d = C_SRL;  end
      17'h00091: begin kind = K_SHI; ctrl_d = C_SRA;  end
      default: begin
        case (in_inst[31:22])
          10'h008: begin kind = K_SIMM; ctrl_d = C_SLT;  end
          10'h009: begin kind = K_SIMM; ctrl_d = C_SLTU; end
          10'h00a: begin kind = K_SIMM; ctrl_d = C_ADD;  end
          10'h00d: begin kind = K_ZIMM; ctrl_d = C_AND;  end
          10'h00e: begin kind = K_ZIMM; ctrl_d = C_OR;   end
          10'h00f: begin kind = K_ZIMM; ctrl_d = C_XOR;  end
          default: begin
            if (in_inst[31:25] == 7'h0a) begin
              kind   = K_LUI;
              ctrl_d = C_LUI;
            end
          end
        endcase
      end
    endcase
  end

  // The ALU shifts alu_rk by alu_rj[4:0], so shift forms put the amount in rj.
  always_comb begin
    rj_d = '0;
    rk_d = '0;
    case (kind)
      K_3R:   begin rj_d = rf_rdata1; rk_d = rf_rdata2; end
      K_SH3:  begin rj_d = rf_rdata2; rk_d = rf_rdata1; end
      K_SHI:  begin rj_d = {27'b0, in_inst[14:10]}; rk_d = rf_rdata1; end
      K_SIMM: begin rj_d = rf_rdata1; rk_d = {{20{in_inst[21]}}, in_inst[21:10]}; end
      K_ZIMM: begin rj_d = rf_rdata1; rk_d = {20'b0, in_inst[21:10]}; end
      K_LUI:  begin rj_d = '0; rk_d = {in_inst[24:5], 12'b0}; end
      default: ;
    endcase
  end

  assign ine_d   = (kind == K_ILL);
  assign we_d    = ~ine_d & (|in_inst[4:0]);
  assign valid_d = flush ? 1'b0 : (capture ? 1'b1 : (out_ready ? 1'b0 : valid_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      ctrl_q  <= '0;
      rj_q    <= '0;
      rk_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      ine_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        pc_q   <= in_pc;
        ctrl_q <= ctrl_d;
        rj_q   <= rj_d;
        rk_q   <= rk_d;
        rd_q   <= in_inst[4:0];
        we_q   <= we_d;
        ine_q  <= ine_d;
      end
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = pc_q;
  assign out_alu_control = ctrl_q;
  assign out_alu_rj      = rj_q;
  assign out_alu_rk      = rk_q;
  assign out_rd          = rd_q;
  assign out_we          = we_q;
  assign out_ine         = ine_q;

endmodule

// File: tb/tb_alu_decode.sv
// Self-checking bench for alu_decode: directed cases, stall/flush/reset
// scenarios and a randomized run against a table-driven reference model.
module tb_alu_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [11:0] out_alu_control;
  logic [31:0] out_alu_rj, out_alu_rk;
  logic [4:0]  out_rd;
  logic        out_we, out_ine;

  int n_checks = 0;
  int n_pass   = 0;

  alu_decode dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_control(out_alu_control), .out_alu_rj(out_alu_rj), .out_alu_rk(out_alu_rk),
    .out_rd(out_rd), .out_we(out_we), .out_ine(out_ine)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] ctrl;
    logic [31:0] rj;
    logic [31:0] rk;
    logic [4:0]  rd;
    logic        we;
    logic        ine;
  } ent_t;

  // Opcode table: value, field width (bits taken from the top), control bit, operand kind.
  // Kinds: 0 3R, 1 3R shift, 2 shift-imm, 3 signed imm12, 4 unsigned imm12, 5 lu12i.
  localparam int NOPS = 21;
  localparam int TBL_OP  [NOPS] = '{'h20,'h22,'h24,'h25,'h28,'h29,'h2a,'h2b,'h2e,'h2f,'h30,
                                    'h81,'h89,'h91,'h08,'h09,'h0a,'h0d,'h0e,'h0f,'h0a};
  localparam int TBL_W   [NOPS] = '{17,17,17,17,17,17,17,17,17,17,17,17,17,17,10,10,10,10,10,10,7};
  localparam int TBL_BIT [NOPS] = '{11,10,9,8,6,7,5,4,3,2,1,3,2,1,9,8,11,7,5,4,0};
  localparam int TBL_K   [NOPS] = '{0,0,0,0,0,0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,5};

  function automatic ent_t ref_model(input logic [31:0] pc, input logic [31:0] inst,
                                     input logic [31:0] a, input logic [31:0] b);
    ent_t e;
    int   hit;
    int   imm;
    e = '0;
    hit = -1;
    e.pc = pc;
    e.rd = inst[4:0];
    for (int i = 0; i < NOPS; i++)
      if ((inst >> (32 - TBL_W[i])) == 32'(TBL_OP[i])) hit = i;
    if (hit < 0) begin
      e.ine = 1'b1;
      return e;
    end
    e.ctrl = 12'h1 << TBL_BIT[hit];
    e.we   = (inst[4:0] != 5'd0);
    imm    = int'((inst >> 10) & 32'hfff);
    case (TBL_K[hit])
      0: begin e.rj = a; e.rk = b; end
      1: begin e.rj = b; e.rk = a; end
      2: begin e.rj = (inst >> 10) & 32'h1f; e.rk = a; end
      3: begin e.rj = a; e.rk = 32'((imm >= 2048) ? imm - 4096 : imm); end
      4: begin e.rj = a; e.rk = 32'(imm); end
      default: begin e.rj = 32'd0; e.rk = ((inst >> 5) & 32'hfffff) << 12; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    int          idx;
    int          w;
    logic [31:0] low;
    if ($urandom_range(0, 7) == 0) return $urandom;
    idx = $urandom_range(0, NOPS - 1);
    w   = TBL_W[idx];
    low = $urandom & ((32'h1 << (32 - w)) - 32'h1);
    if ($urandom_range(0, 5) == 0) low = low & ~32'h1f;
    return (32'(TBL_OP[idx]) << (32 - w)) | low;
  endfunction

  function automatic ent_t observed();
    return {out_pc, out_alu_control, out_alu_rj, out_alu_rk, out_rd, out_we, out_ine};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    in_inst   = inst;
    in_pc     = pc;
    rf_rdata1 = a;
    rf_rdata2 = b;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (observed() !== ent_t'(0)) $display("FAIL reset_outputs: got %h expected 0", observed());
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] d_inst [8];
    logic [31:0] d_a [8];
    logic [31:0] d_b [8];
    ent_t        d_exp [8];
    logic [31:0] pc;
    d_inst[0] = 32'h00100823; d_a[0] = 32'd5;        d_b[0] = 32'd7;
    d_inst[1] = 32'h00170824; d_a[1] = 32'h1;        d_b[1] = 32'h4;
    d_inst[2] = 32'h0048FC24; d_a[2] = 32'h80000001; d_b[2] = 32'h5555AAAA;
    d_inst[3] = 32'h02BFFC25; d_a[3] = 32'h11;       d_b[3] = 32'h99;
    d_inst[4] = 32'h03BFFC25; d_a[4] = 32'h22;       d_b[4] = 32'h98;
    d_inst[5] = 32'h142468A6; d_a[5] = 32'h33;       d_b[5] = 32'h97;
    d_inst[6] = 32'hFFFFFFFF; d_a[6] = 32'h1;        d_b[6] = 32'h2;
    d_inst[7] = 32'h00100820; d_a[7] = 32'd9;        d_b[7] = 32'd10;
    d_exp[0] = {32'h1000, 12'h800, 32'd5,        32'd7,        5'd3,  1'b1, 1'b0};
    d_exp[1] = {32'h1004, 12'h008, 32'h4,        32'h1,        5'd4,  1'b1, 1'b0};
    d_exp[2] = {32'h1008, 12'h002, 32'h1F,       32'h80000001, 5'd4,  1'b1, 1'b0};
    d_exp[3] = {32'h100C, 12'h800, 32'h11,       32'hFFFFFFFF, 5'd5,  1'b1, 1'b0};
    d_exp[4] = {32'h1010, 12'h020, 32'h22,       32'h00000FFF, 5'd5,  1'b1, 1'b0};
    d_exp[5] = {32'h1014, 12'h001, 32'h0,        32'h12345000, 5'd6,  1'b1, 1'b0};
    d_exp[6] = {32'h1018, 12'h000, 32'h0,        32'h0,        5'd31, 1'b0, 1'b1};
    d_exp[7] = {32'h101C, 12'h800, 32'd9,        32'd10,       5'd0,  1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      drive(1'b1, d_inst[i], pc, d_a[i], d_b[i], 1'b1, 1'b0);
      #1;
      n_checks++;
      if ({rf_raddr1, rf_raddr2} !== {d_inst[i][9:5], d_inst[i][14:10]})
        $display("FAIL dir%0d_raddr: got %h/%h expected %h/%h", i, rf_raddr1, rf_raddr2,
                 d_inst[i][9:5], d_inst[i][14:10]);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL dir%0d_valid: got %b expected 1", i, out_valid);
      else n_pass++;
      n_checks++;
      if (observed() !== d_exp[i])
        $display("FAIL dir%0d_entry: got %h expected %h", i, observed(), d_exp[i]);
      else n_pass++;
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL dir_drain_valid: got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] inst_a, inst_b;
    ent_t        exp_a, exp_b;
    inst_a = 32'h00150C41;
    inst_b = 32'h0290A4C7;
    exp_a  = ref_model(32'h2000, inst_a, 32'hAAAA0001, 32'hBBBB0002);
    exp_b  = ref_model(32'h2004, inst_b, 32'hCCCC0003, 32'hDDDD0004);
    drive(1'b1, inst_a, 32'h2000, 32'hAAAA0001, 32'hBBBB0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || observed() !== exp_a)
      $display("FAIL stall_capture: got v=%b %h expected v=1 %h", out_valid, observed(), exp_a);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, inst_b, 32'h2004, 32'hCCCC0003, 32'hDDDD0004, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL stall%0d_in_ready: got %b expected 0", i, in_ready);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || observed() !== exp_a)
        $display("FAIL stall%0d_hold: got v=%b %h expected v=1 %h", i, out_valid, observed(), exp_a);
      else n_pass++;
    end
    drive(1'b1, inst_b, 32'h2004, 32'hCCCC0003, 32'hDDDD0004, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || observed() !== exp_b)
      $display("FAIL b2b_entry: got v=%b %h expected v=1 %h", out_valid, observed(), exp_b);
    else n_pass++;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_retire: got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [31:0] inst_a;
    ent_t        exp_a;
    inst_a = 32'h00128C62;
    exp_a  = ref_model(32'h3000, inst_a, 32'h12, 32'h34);
    drive(1'b1, 32'h00100823, 32'h2FFC, 32'h1, 32'h2, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL flush_empty_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_empty_valid: got %b expected 0", out_valid);
    else n_pass++;
    drive(1'b1, inst_a, 32'h3000, 32'h12, 32'h34, 1'b0, 1'b0);
    @(posedge clk);
    drive(1'b1, 32'h00100823, 32'h3004, 32'h5, 32'h6, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL flush_full_in_ready: got %b expected 0", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_full_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (observed() !== exp_a) $display("FAIL flush_data_hold: got %h expected %h", observed(), exp_a);
    else n_pass++;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h00100823, 32'h4000, 32'h77, 32'h88, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b expected 1", out_valid);
    else n_pass++;
    drive(1'b1, 32'h00100823, 32'h4004, 32'h1, 32'h1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL areset_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (observed() !== ent_t'(0)) $display("FAIL areset_outputs: got %h expected 0", observed());
    else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic        iv, ordy, fl, rdy_exp, cap, m_valid;
    logic [31:0] inst, pc, a, b;
    ent_t        m_ent;
    m_valid = 1'b0;
    m_ent   = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      inst = rand_inst();
      pc   = $urandom;
      a    = $urandom;
      b    = $urandom;
      drive(iv, inst, pc, a, b, ordy, fl);
      #1;
      rdy_exp = ~m_valid | ordy;
      n_checks++;
      if (in_ready !== rdy_exp) $display("FAIL rnd%0d_in_ready: got %b expected %b", cyc, in_ready, rdy_exp);
      else n_pass++;
      n_checks++;
      if (out_valid !== m_valid) $display("FAIL rnd%0d_valid: got %b expected %b", cyc, out_valid, m_valid);
      else n_pass++;
      if (m_valid) begin
        n_checks++;
        if (observed() !== m_ent) $display("FAIL rnd%0d_entry: got %h expected %h", cyc, observed(), m_ent);
        else n_pass++;
      end
      cap = iv & rdy_exp & ~fl;
      if (cap) m_ent = ref_model(pc, inst, a, b);
      m_valid = fl ? 1'b0 : (cap ? 1'b1 : (ordy ? 1'b0 : m_valid));
      @(posedge clk);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_decode.md
# alu_decode

Decode/issue stage feeding the EXE-stage ALU. Accepts one 32-bit LA32R instruction per handshake from fetch and reads two register-file values. It decodes the instruction into the 12-bit one-hot ALU control word plus the two ALU operands, and holds the result in a valid/ready pipeline register toward EXE. It is the producer side of the ALU control/operand interface.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill the held entry and any incoming instruction this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; equals ~out_valid | out_ready (combinational).
- in_pc  in  32  instruction PC.
- in_inst  in  32  instruction word.
- rf_raddr1  out  5  = in_inst[9:5] (rj), combinational.
- rf_raddr2  out  5  = in_inst[14:10] (rk), combinational.
- rf_rdata1, rf_rdata2  in  32 each  same-cycle read data for raddr1/raddr2.
- out_valid  out  1  registered entry valid toward EXE.
- out_ready  in  1  EXE accepts the entry.
- out_pc  out  32  registered PC.
- out_alu_control  out  12  one-hot: [11]add [10]sub [9]slt [8]sltu [7]and [6]nor [5]or [4]xor [3]sll [2]srl [1]sra [0]lui.
- out_alu_rj, out_alu_rk  out  32 each  ALU operand 1 / operand 2.
- out_rd  out  5  destination register, = inst[4:0].
- out_we  out  1  register write enable.
- out_ine  out  1  instruction-not-exist (undecodable word).

## Operation
- Recognised encodings:
  - inst[31:15]: 0x00020 ADD.W, 0x00022 SUB.W, 0x00024 SLT, 0x00025 SLTU, 0x00028 NOR, 0x00029 AND, 0x0002a OR, 0x0002b XOR, 0x0002e SLL.W, 0x0002f SRL.W, 0x00030 SRA.W, 0x00081 SLLI.W, 0x00089 SRLI.W, 0x00091 SRAI.W.
  - inst[31:22]: 0x008 SLTI, 0x009 SLTUI, 0x00a ADDI.W, 0x00d ANDI, 0x00e ORI, 0x00f XORI.
  - inst[31:25]: 0x0a LU12I.W.
- Operand rules. The ALU takes shift amount from alu_rj[4:0] and shift data from alu_rk, and computes alu_rj − alu_rk.
  - 3R arithmetic/logic/compare: alu_rj = rdata1, alu_rk = rdata2.
  - 3R shifts: alu_rj = rdata2 (amount), alu_rk = rdata1 (data). The operands are swapped.
  - Shift-immediate: alu_rj = {27'b0, inst[14:10]}, alu_rk = rdata1.
  - ADDI.W/SLTI/SLTUI: alu_rj = rdata1, alu_rk = sign-extended inst[21:10].
  - ANDI/ORI/XORI: alu_rj = rdata1, alu_rk = zero-extended inst[21:10].
  - LU12I.W: alu_rj = 0, alu_rk = {inst[24:5], 12'b0}.
- Exactly one alu_control bit is set for a legal instruction: immediate forms map to their 3R counterparts, LU12I.W maps to lui.
- Illegal word:
  - out_ine = 1, out_alu_control = 0, out_we = 0, operands = 0.
  - The entry still flows through the handshake so that EXE can raise the exception.
- out_we = legal & (rd != 0).
- Pipeline register:
  - Capture when in_valid & in_ready & ~flush.
  - out_valid next cycle = flush ? 0 : (capture ? 1 : (out_ready ? 0 : out_valid)).
  - With out_valid = 1 and out_ready = 0, all out_* hold stable. in_ready is 0, so nothing is captured.
  - Simultaneous out_ready and in_valid on a full stage: the old entry retires and the new one is captured in the same edge (full throughput).

## Timing
- Latency: 1 cycle from the accepting edge to out_valid.
- Throughput: 1 instruction/cycle while out_ready = 1.
- rf_raddr1/2 are combinational from in_inst. rf_rdata1/2 are sampled on the capture edge only.
- flush has priority over capture and retirement.
  - On the next edge out_valid = 0, whatever in_valid/out_ready are.
  - A flushed incoming instruction is dropped. in_ready still reports ~out_valid | out_ready.
- Reset (asynchronous, any time, including while stalled): out_valid = 0 and every registered output = 0. Held entries are discarded.
- Data outputs may be ignored while out_valid = 0. They change only on capture or reset.

## Test plan
- ADD.W r3,r1,r2 (0x00100823) with rdata1 = 5, rdata2 = 7, out_ready = 1 -> next cycle: out_valid = 1, control = 0x800, rj = 5, rk = 7, rd = 3, we = 1, ine = 0.
- SLL.W r4,r1,r2 with rdata1 = 0x1, rdata2 = 0x4 -> control = 0x008, alu_rj = 0x4, alu_rk = 0x1. SRAI.W r4,r1,31 -> control = 0x002, alu_rj = 0x1F, alu_rk = rdata1.
- ADDI.W r5,r1,-1 -> control = 0x800, alu_rk = 0xFFFFFFFF. ORI r5,r1,0xFFF -> control = 0x020, alu_rk = 0x00000FFF. LU12I.W r6,0x12345 -> control = 0x001, alu_rj = 0, alu_rk = 0x12345000.
- Stall: capture an entry with out_ready = 0 for 3 cycles -> in_ready = 0 and outputs stable throughout. Then out_ready = 1 with in_valid = 1 -> the old entry retires and the new one appears on the next edge, with no bubble.
- Word 0xFFFFFFFF -> ine = 1, control = 0, we = 0, out_valid = 1. ADD.W r0,r1,r2 -> we = 0, ine = 0.
- Assert flush together with in_valid = 1 on an empty stage -> out_valid stays 0. Assert rst mid-stall -> out_valid = 0 immediately (asynchronous) and all outputs = 0.
